// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU control codes and the
// multiply sequencer state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_XOR  = 3'd1;
  localparam logic [2:0] ALU_SLL  = 3'd2;
  localparam logic [2:0] ALU_ADD  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;
  localparam logic [2:0] ALU_BEQ  = 3'd6;
  localparam logic [2:0] ALU_SRAI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq_datapath.sv
// Shift-add datapath for the multiply sequencer: accumulator, multiplicand and
// multiplier registers. MUL_SEQ_EARLY_TERM_EN enables the early-finish hint.
module mul_seq_datapath
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::XLEN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] mcand_i,
  input  logic [W-1:0] mplier_i,
  output logic [W-1:0] acc_o,
  output logic         early_done_o
);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] mcand_q, mcand_d;
  logic [W-1:0] mplier_q, mplier_d;

  // Load operands on start, otherwise consume one multiplier bit per step
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = {mcand_q[W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[W-1:1]};
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc_o = acc_q;

`ifdef MUL_SEQ_EARLY_TERM_EN
  // No multiplier bits remain after this step, so the product is final
  assign early_done_o = (mplier_q[W-1:1] == '0);
`else
  assign early_done_o = 1'b0;
`endif

endmodule

// File: rtl/mul_sequencer.sv
// Iterative radix-2 multiply sequencer for the EX stage: stalls the pipe and
// presents the low product for one cycle. MUL_SEQ_EARLY_TERM_EN allows early finish.
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int         XLEN     = cpu_pkg::XLEN,
  parameter int         CNT_W    = 6,
  parameter logic [2:0] MUL_CODE = cpu_pkg::ALU_MUL
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             start_s, last_s, early_done_s;
  logic [XLEN-1:0]  acc_s;

  assign start_s = valid_i & (alu_ctrl_i == MUL_CODE) & ~flush_i &
                   ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign last_s  = (cnt_q == CNT_W'(XLEN-1)) | early_done_s;

  mul_seq_datapath #(.W(XLEN)) u_datapath (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (start_s),
    .step_i       (state_q == ST_BUSY),
    .mcand_i      (rs1_data_i),
    .mplier_i     (rs2_data_i),
    .acc_o        (acc_s),
    .early_done_o (early_done_s)
  );

  // Next-state, iteration counter and destination latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_BUSY;
        else         state_d = ST_IDLE;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i)     state_d = ST_IDLE;
        else if (last_s) state_d = ST_DONE;
        else             state_d = ST_BUSY;
      end
      ST_DONE: begin
        if (start_s) state_d = ST_BUSY;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_s) begin
      cnt_d = '0;
      rd_d  = rd_addr_i;
    end else begin
      rd_d = rd_q;
    end
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Stall is combinational from start so ID/EX holds the mul while operands load
  always_comb begin
    stall_o = start_s | (state_q == ST_BUSY);
    busy_o  = (state_q == ST_BUSY);
    done_o  = (state_q == ST_DONE);
    if (state_q == ST_DONE) begin
      result_o  = acc_s;
      rd_addr_o = rd_q;
    end else begin
      result_o  = '0;
      rd_addr_o = 5'd0;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table plus hand-written
// reset, flush, done-cycle and back-to-back sequences, with a result scoreboard.
module tb_mul_sequencer;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  alu_ctrl_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [4:0] rd; logic [31:0] exp; } vec_t;
  typedef struct { logic [31:0] res; logic [4:0] rd; } sb_t;
  sb_t sb_q[$];
  vec_t vecs[9];

  mul_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_ctrl_i(alu_ctrl_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected number of BUSY cycles for a given multiplier
  function automatic int busy_len(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  task automatic drive_idle();
    valid_i    = 1'b0;
    alu_ctrl_i = ALU_ADD;
    flush_i    = 1'b0;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
  endtask

  // Present a mul for one cycle (caller is just after a rising edge)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input bit push);
    sb_t e;
    valid_i = 1'b1; alu_ctrl_i = ALU_MUL; flush_i = 1'b0;
    rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    if (push) begin e.res = exp; e.rd = rd; sb_q.push_back(e); end
    @(negedge clk_i);
    check("stall_on_start", 64'(stall_o), 64'(1));
    @(posedge clk_i); #1;
    drive_idle();
  endtask

  task automatic pop_compare(input string tag);
    sb_t e;
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_result"}, 64'(result_o), 64'(e.res));
      check({tag, "_rd"}, 64'(rd_addr_o), 64'(e.rd));
    end
  endtask

  // Count BUSY cycles until done_o, scribbling on the inputs meanwhile
  task automatic wait_done(input int exp_busy, input string tag);
    int cyc;
    bit bad;
    cyc = 0; bad = 1'b0;
    forever begin
      @(negedge clk_i);
      if (done_o === 1'b1 || cyc >= 200) break;
      cyc++;
      if (busy_o !== 1'b1 || stall_o !== 1'b1) bad = 1'b1;
      @(posedge clk_i); #1;
      if (cyc < exp_busy - 1) begin
        valid_i = 1'b1; alu_ctrl_i = ALU_MUL;
        rs1_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = 5'($urandom);
      end else drive_idle();
    end
    check({tag, "_done_seen"}, 64'(done_o), 64'(1));
    check({tag, "_latency"}, 64'(cyc), 64'(exp_busy));
    check({tag, "_busy_stall_held"}, 64'(bad), 64'(0));
    check({tag, "_stall_low_in_done"}, 64'(stall_o), 64'(0));
    check({tag, "_busy_low_in_done"}, 64'(busy_o), 64'(0));
    pop_compare(tag);
    @(posedge clk_i); #1;
    drive_idle();
    @(negedge clk_i);
    check({tag, "_done_one_cycle"}, 64'(done_o), 64'(0));
    @(posedge clk_i); #1;
  endtask

  task automatic no_done_for(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    check({tag, "_quiet"}, 64'(seen), 64'(0));
    @(posedge clk_i); #1;
  endtask

  initial begin
    vecs[0] = '{32'd3, 32'd5, 5'd7, 32'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000001};
    vecs[2] = '{32'h80000000, 32'd2, 5'd1, 32'h00000000};
    vecs[3] = '{32'd7, 32'd9, 5'd3, 32'd63};
    vecs[4] = '{32'd12345, 32'd0, 5'd0, 32'd0};
    vecs[5] = '{32'd12345, 32'd1, 5'd9, 32'd12345};
    vecs[6] = '{32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFE};
    vecs[7] = '{32'd1234, 32'd5678, 5'd6, 32'd7006652};
    vecs[8] = '{32'd5, 32'h80000000, 5'd17, 32'h80000000};

    rst_i = 1'b0;
    drive_idle();
    #1;
    check("reset_stall", 64'(stall_o), 64'(0));
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    check("reset_rd", 64'(rd_addr_o), 64'(0));
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Non-mul codes and valid_i low must never start
    for (int i = 0; i < 8; i++) begin
      valid_i = (i != 5); alu_ctrl_i = 3'(i);
      @(negedge clk_i);
      check("no_start_stall", 64'(stall_o), 64'(0));
      @(posedge clk_i); #1;
    end
    drive_idle();
    no_done_for(3, "no_start");

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
      wait_done(busy_len(vecs[i].b), $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of 7 x 9
    issue(32'd7, 32'd9, 5'd3, 32'd63, 1'b0);
    repeat (9) @(posedge clk_i);
    #1;
    check("midrst_busy_before", 64'(busy_o), 64'(1));
    rst_i = 1'b0;
    #1;
    check("midrst_stall", 64'(stall_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    check("midrst_result", 64'(result_o), 64'(0));
    @(negedge clk_i) rst_i = 1'b1;
    no_done_for(40, "midrst");

    // Flush at T+5 aborts the multiply
    issue(32'd7, 32'd3, 5'd10, 32'd21, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_busy_same_cycle", 64'(busy_o), 64'(1));
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_busy_after", 64'(busy_o), 64'(0));
    check("flush_stall_after", 64'(stall_o), 64'(0));
    no_done_for(40, "flush");
    issue(32'd11, 32'd13, 5'd20, 32'd143, 1'b1);
    wait_done(busy_len(32'd13), "after_flush");

    // flush_i in DONE is ignored and also suppresses a new start
    issue(32'd3, 32'd5, 5'd12, 32'd15, 1'b1);
    repeat (busy_len(32'd5)) @(posedge clk_i);
    #1;
    flush_i = 1'b1; valid_i = 1'b1; alu_ctrl_i = ALU_MUL;
    @(negedge clk_i);
    check("done_flush_done", 64'(done_o), 64'(1));
    check("done_flush_stall", 64'(stall_o), 64'(0));
    pop_compare("done_flush");
    @(posedge clk_i); #1;
    drive_idle();
    no_done_for(3, "done_flush");

    // Back-to-back: 4 x 6 issued in the DONE cycle of 10 x 10
    issue(32'd10, 32'd10, 5'd2, 32'd100, 1'b1);
    repeat (busy_len(32'd10)) @(posedge clk_i);
    #1;
    begin
      sb_t e2;
      e2.res = 32'd24; e2.rd = 5'd8;
      valid_i = 1'b1; alu_ctrl_i = ALU_MUL;
      rs1_data_i = 32'd4; rs2_data_i = 32'd6; rd_addr_i = 5'd8;
      @(negedge clk_i);
      check("b2b_done_first", 64'(done_o), 64'(1));
      check("b2b_stall_second", 64'(stall_o), 64'(1));
      pop_compare("b2b_first");
      sb_q.push_back(e2);
    end
    @(posedge clk_i); #1;
    drive_idle();
    wait_done(busy_len(32'd6), "b2b_second");

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
